pcx2max_mc: RTL and testbench
=============================

PCX2MAX_MC -- requirements
Module: pcx2max_mc

Interface
REQ-001 SHALL have parameter NUM_CORES, default 4, number of SPARC core request channels (1..8).
REQ-002 SHALL have parameter PCX_WIDTH, default 124, PCX packet width in bits.
REQ-003 SHALL have parameter OUT_WIDTH, default 32, host word width (16..64).
REQ-004 SHALL have port clk, input, 1, sole clock; all logic on rising edge.
REQ-005 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-006 SHALL have port core_req, input, NUM_CORES, per-core request strobe (pq stage).
REQ-007 SHALL have port core_atom, input, NUM_CORES, per-core atomic flag, sampled with core_req.
REQ-008 SHALL have port core_data, input, NUM_CORES*PCX_WIDTH, per-core packet (pa stage); core i at bits [i*PCX_WIDTH +: PCX_WIDTH].
REQ-009 SHALL have port core_grant, output, NUM_CORES, per-core one-cycle grant/credit return.
REQ-010 SHALL have port pcx_valid, output, 1, host word valid.
REQ-011 SHALL have port pcx_stall, input, 1, host backpressure; word not accepted this cycle.
REQ-012 SHALL have port pcx_data, output, OUT_WIDTH, host word.
REQ-013 SHALL have port err_overflow, output, 1, sticky buffer-overflow flag.

Function
REQ-014 SHALL register core_atom at the cycle core_req[i]=1 (t) and capture core_data slice i at t+1, writing {atom,packet} into core i's 2-entry FIFO at end of t+1.
REQ-015 SHALL, if core i's FIFO is full at write time, drop the packet and set err_overflow=1 until reset.
REQ-016 SHALL transfer a word only on a cycle with pcx_valid=1 and pcx_stall=0; pcx_data and pcx_valid SHALL hold stable while stalled.
REQ-017 SHALL run FSM IDLE -> HDR -> DATA -> IDLE; IDLE selects a core, HDR drives header word, DATA drives NW=ceil(PCX_WIDTH/OUT_WIDTH) data words (5 total words at defaults).
REQ-018 SHALL, in IDLE, pick the first non-empty core searching round-robin from (last_served+1) mod NUM_CORES and enter HDR next cycle; pcx_valid=0 in IDLE.
REQ-019 SHALL form header: bits[2:0]=core index, bit[3]=atom, bits[7:4]=4'hA, all higher bits 0.
REQ-020 SHALL send data words most-significant first, first word zero-padded in its unused upper bits.
REQ-021 SHALL, on acceptance of the last data word, pop that core's FIFO, update last_served, and return to IDLE; a new header SHALL not appear before the following cycle (one idle cycle minimum between packets).
REQ-022 SHALL pulse core_grant[i]=1 for exactly one cycle, on the cycle after the last data word of core i is accepted.
REQ-023 SHALL, after serving a packet with atom=1, lock arbitration to the same core: IDLE waits (pcx_valid=0) until that core's FIFO is non-empty, serves it, then clears the lock regardless of that packet's atom bit.
REQ-024 SHALL support simultaneous FIFO write and pop on the same core in one cycle with no loss; a full FIFO being popped in the write cycle SHALL NOT overflow.
REQ-025 SHALL accept core_req on multiple cores in the same cycle, each into its own FIFO.

Reset
REQ-026 SHALL on rst=1: FSM=IDLE, all FIFOs empty, last_served=NUM_CORES-1 (core 0 first), atomic lock cleared, err_overflow=0, pcx_valid=0, pcx_data=0, core_grant=0.
REQ-027 SHALL, on reset mid-packet, abandon the in-flight packet with no grant issued; pcx_valid=0 the cycle after rst is sampled.
REQ-028 SHALL ignore core_req while rst=1 and pending pa-stage captures from the reset cycle.

Verification
REQ-029 Single packet: core 2 req at t, data 124'h0123...CDEF, atom=0, stall=0 -> header 32'h000000A2 at t+3, then 4 data words MS first (first word upper 4 bits 0), core_grant[2] pulse at t+8.
REQ-030 Stall: assert pcx_stall for 3 cycles during data word 2 -> word 2 held unchanged, total 8 cycles valid, no duplicated or skipped word.
REQ-031 Round-robin: cores 0,1,3 request same cycle -> headers in order core0, core1, core3; repeat with last_served=1 -> core3, core0, core1.
REQ-032 Atomic: core 1 sends atom=1 then, 6 cycles later, atom=0 while core 0 pending -> core 1 packets back-to-back, core 0 served after; header bit3=1 on first only.
REQ-033 Overflow: core 0 issues 3 requests with stall=1 held -> third dropped, err_overflow=1 until rst; after release exactly 2 packets and 2 grants.
REQ-034 Reset mid-packet: rst during DATA word 3 -> pcx_valid=0 next cycle, no grant, all FIFOs empty, next request served from header.

Source files
------------

// File: rtl/pcx2max_mc_if.sv
// Bundle carrying the per-core PCX request channels and the host word stream.
interface pcx2max_mc_if #(
  parameter int unsigned NUM_CORES = 4,
  parameter int unsigned PCX_WIDTH = 124,
  parameter int unsigned OUT_WIDTH = 32
);
  logic [NUM_CORES-1:0]           core_req;
  logic [NUM_CORES-1:0]           core_atom;
  logic [NUM_CORES*PCX_WIDTH-1:0] core_data;
  logic [NUM_CORES-1:0]           core_grant;
  logic                           pcx_valid;
  logic                           pcx_stall;
  logic [OUT_WIDTH-1:0]           pcx_data;
  logic                           err_overflow;

  modport master (
    output core_req, core_atom, core_data, pcx_stall,
    input  core_grant, pcx_valid, pcx_data, err_overflow
  );

  modport slave (
    input  core_req, core_atom, core_data, pcx_stall,
    output core_grant, pcx_valid, pcx_data, err_overflow
  );
endinterface

// File: rtl/pcx2max_mc.sv
// Merges per-core PCX packets into a single host word stream: header word plus
// MS-first data words, round-robin arbitration with atomic lock, credit return.
module pcx2max_mc #(
  parameter int unsigned NUM_CORES = 4,
  parameter int unsigned PCX_WIDTH = 124,
  parameter int unsigned OUT_WIDTH = 32
) (
  input logic        clk,
  input logic        rst,
  pcx2max_mc_if.slave bus
);

  localparam int unsigned NW   = (PCX_WIDTH + OUT_WIDTH - 1) / OUT_WIDTH;
  localparam int unsigned PADW = NW * OUT_WIDTH;
  localparam int unsigned EW   = PCX_WIDTH + 1;
  localparam int unsigned CW   = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
  localparam int unsigned IW   = (NW > 1) ? $clog2(NW) : 1;

  typedef enum logic [1:0] {IDLE, HDR, DATA} state_t;

  logic [NUM_CORES-1:0] req_q;
  logic [NUM_CORES-1:0] atom_q;
  logic [EW-1:0]        mem [NUM_CORES][2];
  logic [NUM_CORES-1:0] wr_ptr;
  logic [NUM_CORES-1:0] rd_ptr;
  logic [1:0]           cnt [NUM_CORES];
  logic                 err_q;

  state_t               state;
  logic [CW-1:0]        cur;
  logic [CW-1:0]        last_served;
  logic [CW-1:0]        lock_core;
  logic                 lock;
  logic [IW-1:0]        widx;
  logic                 pcx_valid_q;
  logic [OUT_WIDTH-1:0] pcx_data_q;
  logic [NUM_CORES-1:0] grant_q;

  logic                 accept_c;
  logic                 last_c;
  logic [NUM_CORES-1:0] pop_vec_c;
  logic [NUM_CORES-1:0] wr_ok_c;
  logic                 sel_found_c;
  logic [CW-1:0]        sel_core_c;
  logic [CW-1:0]        cand_c;
  logic [EW-1:0]        sel_head_c;
  logic [EW-1:0]        cur_head_c;
  logic [OUT_WIDTH-1:0] hdr_c;
  logic [PADW-1:0]      padded_c;
  logic [OUT_WIDTH-1:0] words_c [NW];
  logic [OUT_WIDTH-1:0] next_word_c;

  assign bus.core_grant   = grant_q;
  assign bus.pcx_valid    = pcx_valid_q;
  assign bus.pcx_data     = pcx_data_q;
  assign bus.err_overflow = err_q;

  // pq stage: strobe and atomic flag; data follows one cycle later
  always_ff @(posedge clk) begin
    if (rst) begin
      req_q  <= '0;
      atom_q <= '0;
    end else begin
      req_q  <= bus.core_req;
      atom_q <= bus.core_atom;
    end
  end

  assign accept_c = pcx_valid_q & ~bus.pcx_stall;
  assign last_c   = (state == DATA) && accept_c && (widx == IW'(NW - 1));

  always_comb begin
    pop_vec_c = '0;
    if (last_c) pop_vec_c[cur] = 1'b1;
  end

  // A full FIFO that pops this cycle frees the slot the write lands in
  always_comb begin
    wr_ok_c = '0;
    for (int unsigned i = 0; i < NUM_CORES; i++) begin
      wr_ok_c[i] = req_q[i] && ((cnt[i] != 2'd2) || pop_vec_c[i]);
    end
  end

  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < NUM_CORES; i++) begin
      if (wr_ok_c[i]) begin
        mem[i][wr_ptr[i]] <= {atom_q[i], bus.core_data[i*PCX_WIDTH +: PCX_WIDTH]};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      err_q  <= 1'b0;
      for (int unsigned i = 0; i < NUM_CORES; i++) cnt[i] <= 2'd0;
    end else begin
      for (int unsigned i = 0; i < NUM_CORES; i++) begin
        if (wr_ok_c[i])             wr_ptr[i] <= ~wr_ptr[i];
        if (pop_vec_c[i])           rd_ptr[i] <= ~rd_ptr[i];
        if (req_q[i] && !wr_ok_c[i]) err_q    <= 1'b1;
        cnt[i] <= cnt[i] + 2'(wr_ok_c[i]) - 2'(pop_vec_c[i]);
      end
    end
  end

  // Round-robin search from last_served+1, or wait on the locked core
  always_comb begin
    sel_found_c = 1'b0;
    sel_core_c  = '0;
    cand_c      = '0;
    if (lock) begin
      sel_found_c = (cnt[lock_core] != 2'd0);
      sel_core_c  = lock_core;
    end else begin
      for (int unsigned k = 1; k <= NUM_CORES; k++) begin
        cand_c = CW'((32'(last_served) + k) % NUM_CORES);
        if (!sel_found_c && (cnt[cand_c] != 2'd0)) begin
          sel_found_c = 1'b1;
          sel_core_c  = cand_c;
        end
      end
    end
  end

  assign sel_head_c = mem[sel_core_c][rd_ptr[sel_core_c]];
  assign cur_head_c = mem[cur][rd_ptr[cur]];

  always_comb begin
    hdr_c      = '0;
    hdr_c[2:0] = 3'(sel_core_c);
    hdr_c[3]   = sel_head_c[PCX_WIDTH];
    hdr_c[7:4] = 4'hA;
  end

  assign padded_c = PADW'(cur_head_c[PCX_WIDTH-1:0]);

  always_comb begin
    for (int unsigned k = 0; k < NW; k++) begin
      words_c[k] = padded_c[(NW-1-k)*OUT_WIDTH +: OUT_WIDTH];
    end
  end

  always_comb begin
    next_word_c = '0;
    for (int unsigned k = 0; k < NW; k++) begin
      if (32'(widx) + 32'd1 == k) next_word_c = words_c[k];
    end
  end

  // Packet sequencer; outputs are loaded one edge ahead of the cycle they show
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cur         <= '0;
      last_served <= CW'(NUM_CORES - 1);
      lock        <= 1'b0;
      lock_core   <= '0;
      widx        <= '0;
      pcx_valid_q <= 1'b0;
      pcx_data_q  <= '0;
      grant_q     <= '0;
    end else begin
      grant_q <= '0;
      case (state)
        IDLE: begin
          if (sel_found_c) begin
            cur         <= sel_core_c;
            pcx_data_q  <= hdr_c;
            pcx_valid_q <= 1'b1;
            state       <= HDR;
          end
        end
        HDR: begin
          if (accept_c) begin
            pcx_data_q <= words_c[0];
            widx       <= '0;
            state      <= DATA;
          end
        end
        DATA: begin
          if (accept_c) begin
            if (widx == IW'(NW - 1)) begin
              pcx_valid_q <= 1'b0;
              pcx_data_q  <= '0;
              grant_q     <= NUM_CORES'(1) << cur;
              last_served <= cur;
              if (lock) begin
                lock <= 1'b0;
              end else if (cur_head_c[PCX_WIDTH]) begin
                lock      <= 1'b1;
                lock_core <= cur;
              end
              state <= IDLE;
            end else begin
              widx       <= widx + IW'(1);
              pcx_data_q <= next_word_c;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pcx2max_mc.sv
// Directed bench for pcx2max_mc: a negedge monitor logs accepted words and grants,
// and each scenario compares the logs against hand-computed sequences.
module tb_pcx2max_mc;

  localparam int unsigned NC = 4;
  localparam int unsigned PW = 124;
  localparam int unsigned OW = 32;

  localparam logic [PW-1:0] P1 = 124'h123_4567_89AB_CDEF_0123_4567_89AB_CDEF;
  localparam logic [PW-1:0] P2 = 124'h111_1111_2222_2222_3333_3333_4444_4444;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pcx2max_mc_if #(.NUM_CORES(NC), .PCX_WIDTH(PW), .OUT_WIDTH(OW)) bus ();

  pcx2max_mc #(.NUM_CORES(NC), .PCX_WIDTH(PW), .OUT_WIDTH(OW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int vcnt  = 0;
  int t;

  logic [31:0] obs_w [$];
  int          obs_c [$];
  logic [3:0]  gnt_v [$];
  int          gnt_c [$];
  logic        hold_q = 1'b0;
  logic [31:0] hold_d = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Record transfers and grants; words must stay frozen across a stall
  always @(negedge clk) begin
    if (bus.core_grant != '0) begin
      gnt_v.push_back(bus.core_grant);
      gnt_c.push_back(cyc);
    end
    if (rst) begin
      hold_q = 1'b0;
    end else begin
      if (hold_q) begin
        chk("hold_valid", 64'(bus.pcx_valid), 64'd1);
        chk("hold_data", 64'(bus.pcx_data), 64'(hold_d));
      end
      if (bus.pcx_valid) vcnt++;
      if (bus.pcx_valid && !bus.pcx_stall) begin
        obs_w.push_back(bus.pcx_data);
        obs_c.push_back(cyc);
      end
      hold_q = bus.pcx_valid && bus.pcx_stall;
      hold_d = bus.pcx_data;
    end
  end

  function automatic logic [31:0] getw(input int k);
    if (k < obs_w.size()) return obs_w[k];
    return 32'hDEAD_BEEF;
  endfunction

  function automatic int getc(input int k);
    if (k < obs_c.size()) return obs_c[k];
    return -1;
  endfunction

  function automatic logic [3:0] getg(input int k);
    if (k < gnt_v.size()) return gnt_v[k];
    return 4'hF;
  endfunction

  function automatic int getgc(input int k);
    if (k < gnt_c.size()) return gnt_c[k];
    return -1;
  endfunction

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    obs_w.delete();
    obs_c.delete();
    gnt_v.delete();
    gnt_c.delete();
    vcnt = 0;
  endtask

  task automatic set_pk(input int core, input logic [PW-1:0] val);
    bus.core_data[core*PW +: PW] = val;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.core_req  = '0;
    bus.core_atom = '0;
    step(2);
    rst = 1'b0;
  endtask

  task automatic pulse_req(input logic [3:0] req, input logic [3:0] atom);
    bus.core_req  = req;
    bus.core_atom = atom;
    t = cyc;
    step(1);
    bus.core_req  = '0;
    bus.core_atom = '0;
  endtask

  initial begin
    logic [31:0] exp_w [5];
    rst           = 1'b1;
    bus.core_req  = '0;
    bus.core_atom = '0;
    bus.core_data = '0;
    bus.pcx_stall = 1'b0;
    step(3);

    chk("rst_valid", 64'(bus.pcx_valid), 64'd0);
    chk("rst_data", 64'(bus.pcx_data), 64'd0);
    chk("rst_grant", 64'(bus.core_grant), 64'd0);
    chk("rst_err", 64'(bus.err_overflow), 64'd0);
    rst = 1'b0;
    step(1);

    // Single packet from core 2
    clear_logs();
    set_pk(2, P1);
    pulse_req(4'b0100, 4'b0000);
    step(11);
    exp_w = '{32'h0000_00A2, 32'h0123_4567, 32'h89AB_CDEF, 32'h0123_4567, 32'h89AB_CDEF};
    chk("single_n", 64'(obs_w.size()), 64'd5);
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("single_w%0d", k), 64'(getw(k)), 64'(exp_w[k]));
      chk($sformatf("single_c%0d", k), 64'(getc(k)), 64'(t + 3 + k));
    end
    chk("single_gn", 64'(gnt_v.size()), 64'd1);
    chk("single_g", 64'(getg(0)), 64'(4'b0100));
    chk("single_gc", 64'(getgc(0)), 64'(t + 8));

    // Stall three cycles on data word 2
    clear_logs();
    set_pk(1, P2);
    pulse_req(4'b0010, 4'b0000);
    step(4);
    bus.pcx_stall = 1'b1;
    step(3);
    bus.pcx_stall = 1'b0;
    step(8);
    exp_w = '{32'h0000_00A1, 32'h0111_1111, 32'h2222_2222, 32'h3333_3333, 32'h4444_4444};
    chk("stall_n", 64'(obs_w.size()), 64'd5);
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("stall_w%0d", k), 64'(getw(k)), 64'(exp_w[k]));
    end
    chk("stall_c2", 64'(getc(2)), 64'(t + 8));
    chk("stall_c4", 64'(getc(4)), 64'(t + 10));
    chk("stall_vcnt", 64'(vcnt), 64'd8);
    chk("stall_gc", 64'(getgc(0)), 64'(t + 11));

    // Round-robin from reset, then from last_served=1
    do_reset();
    clear_logs();
    set_pk(0, 124'hC0);
    set_pk(3, 124'hC3);
    pulse_req(4'b1011, 4'b0000);
    step(25);
    chk("rr1_n", 64'(obs_w.size()), 64'd15);
    chk("rr1_h0", 64'(getw(0)), 64'h0A0);
    chk("rr1_h1", 64'(getw(5)), 64'h0A1);
    chk("rr1_h2", 64'(getw(10)), 64'h0A3);
    chk("rr1_h1c", 64'(getc(5)), 64'(t + 9));
    chk("rr1_g0", 64'(getg(0)), 64'(4'b0001));
    chk("rr1_g2", 64'(getg(2)), 64'(4'b1000));
    clear_logs();
    pulse_req(4'b0010, 4'b0000);
    step(10);
    clear_logs();
    pulse_req(4'b1011, 4'b0000);
    step(25);
    chk("rr2_h0", 64'(getw(0)), 64'h0A3);
    chk("rr2_h1", 64'(getw(5)), 64'h0A0);
    chk("rr2_h2", 64'(getw(10)), 64'h0A1);
    chk("rr2_g1", 64'(getg(1)), 64'(4'b0001));

    // Atomic lock: core 1 served twice before pending core 0
    clear_logs();
    pulse_req(4'b0010, 4'b0010);
    bus.core_req = 4'b0001;
    step(1);
    bus.core_req = '0;
    step(4);
    bus.core_req = 4'b0010;
    step(1);
    bus.core_req = '0;
    step(20);
    chk("atom_n", 64'(obs_w.size()), 64'd15);
    chk("atom_h0", 64'(getw(0)), 64'h0A9);
    chk("atom_h1", 64'(getw(5)), 64'h0A1);
    chk("atom_h2", 64'(getw(10)), 64'h0A0);
    chk("atom_c1", 64'(getc(5)), 64'(t + 9));
    chk("atom_c2", 64'(getc(10)), 64'(t + 15));
    chk("atom_g1", 64'(getg(1)), 64'(4'b0010));
    chk("atom_g2", 64'(getg(2)), 64'(4'b0001));

    // Overflow: three back-to-back requests into a 2-deep FIFO under stall
    do_reset();
    clear_logs();
    bus.pcx_stall = 1'b1;
    set_pk(0, 124'h1);
    bus.core_req = 4'b0001;
    step(1);
    step(1);
    set_pk(0, 124'h2);
    step(1);
    bus.core_req = '0;
    set_pk(0, 124'h3);
    step(2);
    chk("ovf_err", 64'(bus.err_overflow), 64'd1);
    chk("ovf_hdr_v", 64'(bus.pcx_valid), 64'd1);
    chk("ovf_hdr_d", 64'(bus.pcx_data), 64'h0A0);
    step(3);
    bus.pcx_stall = 1'b0;
    step(20);
    chk("ovf_n", 64'(obs_w.size()), 64'd10);
    chk("ovf_p0", 64'(getw(4)), 64'd1);
    chk("ovf_h1", 64'(getw(5)), 64'h0A0);
    chk("ovf_p1", 64'(getw(9)), 64'd2);
    chk("ovf_gn", 64'(gnt_v.size()), 64'd2);
    chk("ovf_g1", 64'(getg(1)), 64'(4'b0001));
    chk("ovf_sticky", 64'(bus.err_overflow), 64'd1);
    do_reset();
    chk("ovf_clr", 64'(bus.err_overflow), 64'd0);

    // Reset during data word 3, with a core 1 request in the reset cycle
    clear_logs();
    set_pk(2, P1);
    pulse_req(4'b0100, 4'b0000);
    step(5);
    rst = 1'b1;
    bus.core_req = 4'b0010;
    step(1);
    chk("mid_valid", 64'(bus.pcx_valid), 64'd0);
    chk("mid_data", 64'(bus.pcx_data), 64'd0);
    rst = 1'b0;
    bus.core_req = '0;
    step(12);
    chk("mid_gn", 64'(gnt_v.size()), 64'd0);
    chk("mid_n", 64'(obs_w.size()), 64'd3);
    clear_logs();
    pulse_req(4'b1000, 4'b0000);
    step(10);
    chk("post_h", 64'(getw(0)), 64'h0A3);
    chk("post_c", 64'(getc(0)), 64'(t + 3));
    chk("post_g", 64'(getg(0)), 64'(4'b1000));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
